// File: rtl/tx_sample_serializer.sv
// Block-oriented TX sample serializer: DEPTH slots loaded in IDLE, committed, then emitted one per txstrobe.
// Optional underrun counter (underrun_cnt / cnt_clr) is enabled by defining TXSER_UNDERRUN_CNT_EN.
module tx_sample_serializer #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             txstrobe,
  input  logic             wr_en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
`ifdef TXSER_UNDERRUN_CNT_EN
  input  logic             cnt_clr,
  output logic [15:0]      underrun_cnt,
`endif
  output logic [WIDTH-1:0] out_sample,
  output logic             out_valid,
  output logic             ready,
  output logic             busy,
  output logic             underrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] slot_r [DEPTH];
  logic [2:0]       idx_r;
  logic [WIDTH-1:0] out_sample_r;
  logic             out_valid_r;
  logic             underrun_r;
  logic             ready_r;
  logic             busy_r;
  logic             idle_strobe_s;

  assign idle_strobe_s = (state_r == ST_IDLE) && txstrobe;

  // Control FSM, slot storage and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= 3'd0;
      out_sample_r <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      underrun_r   <= 1'b0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      out_valid_r <= 1'b0;
      underrun_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Slots are writable only here; a write alongside commit lands in the block
          for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (sel == 3'(i + 1))) begin
              slot_r[i] <= wr_data;
            end
          end
          if (txstrobe) begin
            out_sample_r <= {WIDTH{1'b0}};
            underrun_r   <= 1'b1;
          end
          if (commit) begin
            state_r <= ST_ARMED;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (txstrobe) begin
            out_sample_r <= slot_r[0];
            out_valid_r  <= 1'b1;
            idx_r        <= 3'd1;
            state_r      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (txstrobe) begin
            out_sample_r <= slot_r[idx_r];
            out_valid_r  <= 1'b1;
            if (idx_r == 3'(DEPTH - 1)) begin
              idx_r   <= 3'd0;
              state_r <= ST_IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= 3'd0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TXSER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_r;

  // Saturating underrun counter; clear has priority over a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_cnt_r <= 16'd0;
    end else if (cnt_clr) begin
      underrun_cnt_r <= 16'd0;
    end else if (idle_strobe_s && (underrun_cnt_r != 16'hFFFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 16'd1;
    end else begin
      underrun_cnt_r <= underrun_cnt_r;
    end
  end

  assign underrun_cnt = underrun_cnt_r;
`endif

  assign out_sample = out_sample_r;
  assign out_valid  = out_valid_r;
  assign underrun   = underrun_r;
  assign ready      = ready_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_tx_sample_serializer.sv
// Self-checking bench for tx_sample_serializer: directed plan followed by random traffic against a queue-based model.
module tb_tx_sample_serializer;

  localparam int DEPTH = 6;
  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             txstrobe;
  logic             wr_en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] wr_data;
  logic             commit;
  logic [WIDTH-1:0] out_sample;
  logic             out_valid;
  logic             ready;
  logic             busy;
  logic             underrun;
`ifdef TXSER_UNDERRUN_CNT_EN
  logic             cnt_clr;
  logic [15:0]      underrun_cnt;
  int               m_cnt;
`endif

  int checks;
  int failures;

  // reference model: stored slots and the not-yet-emitted part of a committed block
  logic [WIDTH-1:0] m_slot [DEPTH];
  logic [WIDTH-1:0] m_pend [$];
  logic [WIDTH-1:0] m_out;
  logic             m_valid;
  logic             m_under;
  logic [WIDTH-1:0] got_q [$];

  tx_sample_serializer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .txstrobe(txstrobe),
    .wr_en(wr_en),
    .sel(sel),
    .wr_data(wr_data),
    .commit(commit),
`ifdef TXSER_UNDERRUN_CNT_EN
    .cnt_clr(cnt_clr),
    .underrun_cnt(underrun_cnt),
`endif
    .out_sample(out_sample),
    .out_valid(out_valid),
    .ready(ready),
    .busy(busy),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
    m_pend.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_under = 1'b0;
`ifdef TXSER_UNDERRUN_CNT_EN
    m_cnt = 0;
`endif
  endtask

  // one clock: drive inputs, advance the model, compare all outputs just after the edge
  task automatic step(input logic s, input logic w, input logic [2:0] sl,
                      input logic [WIDTH-1:0] d, input logic c, input logic clr);
    bit was_idle;
    @(negedge clk);
    txstrobe = s; wr_en = w; sel = sl; wr_data = d; commit = c;
`ifdef TXSER_UNDERRUN_CNT_EN
    cnt_clr = clr;
`endif
    was_idle = (m_pend.size() == 0);
    m_valid  = 1'b0;
    m_under  = 1'b0;
    if (s) begin
      if (was_idle) begin
        m_under = 1'b1;
        m_out   = '0;
      end else begin
        m_out   = m_pend.pop_front();
        m_valid = 1'b1;
      end
    end
    if (was_idle) begin
      if (w && sl >= 3'd1 && sl <= 3'(DEPTH)) m_slot[sl - 3'd1] = d;
      if (c) for (int i = 0; i < DEPTH; i++) m_pend.push_back(m_slot[i]);
    end
`ifdef TXSER_UNDERRUN_CNT_EN
    if (clr) m_cnt = 0;
    else if (m_under && m_cnt < 65535) m_cnt++;
`endif
    @(posedge clk);
    #1;
    check("out_sample", 32'(out_sample), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("underrun", 32'(underrun), 32'(m_under));
    check("ready", 32'(ready), 32'(m_pend.size() == 0));
    check("busy", 32'(busy), 32'(m_pend.size() != 0));
`ifdef TXSER_UNDERRUN_CNT_EN
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
    if (out_valid) got_q.push_back(out_sample);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic strobe();
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_out_sample", 32'(out_sample), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] first_seq [$];
    checks = 0; failures = 0;
    reset = 1'b1; txstrobe = 1'b0; wr_en = 1'b0; sel = 3'd0; wr_data = '0; commit = 1'b0;
`ifdef TXSER_UNDERRUN_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    do_reset();
    idle(2);

    // underrun from reset
    for (int k = 0; k < 3; k++) begin strobe(); idle(2); end
    check("underrun_no_valid", 32'(got_q.size()), 32'd0);
`ifdef TXSER_UNDERRUN_CNT_EN
    check("cnt_after_3", 32'(underrun_cnt), 32'd3);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    check("cnt_cleared", 32'(underrun_cnt), 32'd0);
`endif

    // normal send with strobes 4 cycles apart
    for (int k = 1; k <= DEPTH; k++) step(1'b0, 1'b1, 3'(k), 16'(k * 16'h0011), 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
    for (int k = 1; k <= DEPTH; k++) begin
      strobe();
      check("normal_sample", 32'(out_sample), 32'(k * 16'h0011));
      idle(3);
    end
    check("normal_ready", 32'(ready), 32'h1);

    // locked slots during ARMED and SEND
    got_q.delete();
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'd2, 16'hBEEF, 1'b0, 1'b0);
    strobe();
    step(1'b0, 1'b1, 3'd2, 16'hBEEF, 1'b1, 1'b0);
    for (int k = 1; k < DEPTH; k++) strobe();
    check("locked_second", 32'(got_q[1]), 32'h0022);

    // invalid sel, then write+commit together, back-to-back strobes
    got_q.delete();
    step(1'b0, 1'b1, 3'd0, 16'hDEAD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd7, 16'hDEAD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd6, 16'h1234, 1'b1, 1'b0);
    for (int k = 0; k < DEPTH; k++) strobe();
    check("invalid_sel_slot1", 32'(got_q[0]), 32'h0011);
    check("combined_sixth", 32'(got_q[5]), 32'h1234);
    first_seq = got_q;

    // resend without rewriting, strobe coinciding with commit counts as underrun
    got_q.delete();
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
    check("commit_strobe_underrun", 32'(underrun), 32'h1);
    for (int k = 0; k < DEPTH; k++) strobe();
    check("resend_count", 32'(got_q.size()), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) check("resend_sample", 32'(got_q[k]), 32'(first_seq[k]));

    // reset mid-send after 3rd strobe
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) strobe();
    do_reset();
    got_q.delete();
    strobe();
    check("post_reset_underrun", 32'(underrun), 32'h1);
    idle(1);
    check("post_reset_no_valid", 32'(got_q.size()), 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_sample_serializer.md
Name: tx_sample_serializer

Overview:
Transmit-side counterpart to the RX sample capture chain. The host side loads a block of DEPTH 16-bit samples into indexed slots, then commits the block. The block emits one sample per txstrobe toward the TX DSP path. It sits between the in-band packet writer and the TX interpolator. When no block is committed it flags underrun and emits zeros.

Parameters:
DEPTH, 6, number of sample slots; slot indices 1..DEPTH, supported range 2..7
WIDTH, 16, sample width in bits

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
txstrobe  input  1  one-cycle pulse per TX sample period
wr_en  input  1  write slot strobe
sel  input  3  slot index for write; valid 1..DEPTH, all other values ignored
wr_data  input  WIDTH  sample to write
commit  input  1  marks loaded block ready to send
out_sample  output  WIDTH  current TX sample
out_valid  output  1  one-cycle pulse; out_sample updated from a committed block
ready  output  1  high in IDLE; slots writable
busy  output  1  high in ARMED or SEND
underrun  output  1  one-cycle pulse; txstrobe seen in IDLE

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, all slots=0, idx=0.
  - out_sample=0, out_valid=0, underrun=0, ready=1, busy=0.
  - Reset takes effect mid-send: the in-flight block is discarded.
- States: IDLE, ARMED, SEND.
  - ready = (state==IDLE); busy = !ready. Both are registered-state decodes, with no combinational path from inputs.
- IDLE:
  - wr_en with sel in 1..DEPTH writes slot[sel-1] <= wr_data. Other sel values are ignored with no side effect.
  - commit -> ARMED next cycle.
  - wr_en and commit in the same cycle: the write lands and is part of the committed block.
  - txstrobe in IDLE: out_sample <= 0, underrun pulses for 1 cycle, out_valid stays 0.
  - txstrobe together with commit in IDLE: counts as an underrun; the block still arms, and the first sample goes out on the next txstrobe.
- ARMED:
  - wr_en and commit are ignored; slots are frozen.
  - txstrobe: out_sample <= slot[0], out_valid pulses, idx <= 1, -> SEND.
- SEND:
  - wr_en and commit are ignored.
  - txstrobe: out_sample <= slot[idx], out_valid pulses.
  - If idx==DEPTH-1: idx <= 0, -> IDLE. Otherwise idx <= idx+1.
- Latency and output hold:
  - out_sample and out_valid change on the clk edge that samples txstrobe high, so they are visible 1 cycle after the strobe.
  - out_sample holds its value between strobes.
- Emission order: slot 1 first, slot DEPTH last.
- Slot contents persist after a send. Re-committing without rewriting resends the same data.
- Back-to-back txstrobe on consecutive cycles is legal; one sample is emitted per strobe.

Optional Feature:
TXSER_UNDERRUN_CNT_EN
- Defined:
  - Adds output underrun_cnt [15:0].
  - Increments on every underrun pulse and saturates at 16'hFFFF.
  - Reset value 0.
  - Cleared by a one-cycle input cnt_clr. cnt_clr wins over a simultaneous increment.
- Undefined: neither port exists. The underrun pulse behaviour is unchanged.

Test Plan:
1. Normal send: write slots 1..6 = 16'h0011..16'h0066, then commit, then 6 txstrobes spaced 4 cycles apart.
   - Required: out_sample = 0011, 0022, 0033, 0044, 0055, 0066, each 1 cycle after its strobe.
   - Required: 6 out_valid pulses, then ready=1.
2. Underrun: from reset, 3 txstrobes with no commit.
   - Required: 3 underrun pulses, out_sample=0, out_valid never asserted.
   - Required with TXSER_UNDERRUN_CNT_EN: underrun_cnt=3. After cnt_clr: 0.
3. Locked slots: commit a block, then write sel=2 data=16'hBEEF during ARMED and again during SEND.
   - Required: second emitted sample is the original slot-2 value; 16'hBEEF never appears.
4. Invalid sel and combined write/commit:
   - Write sel=0 and sel=7 with 16'hDEAD; all slots stay unchanged.
   - wr_en sel=6 data=16'h1234 with commit in the same cycle: sixth emitted sample = 1234.
5. Reset mid-send: assert reset low after the 3rd txstrobe of a block.
   - Required: immediately out_sample=0, ready=1, busy=0.
   - Required: after release, txstrobe gives underrun and no out_valid.
6. Resend: after a completed block, commit again without writes and send 6 strobes.
   - Required: the identical 6-sample sequence is emitted again.
   - Back-to-back strobes on consecutive cycles emit consecutive samples with no skips.
